div_seq: RTL and testbench

- Multi-cycle sequencer for the MIPS DIV/DIVU instructions.
- Sits in the execute stage beside the ALU. It receives operands when the decoder selects DIV_CONTROL or DIVU_CONTROL.
- Runs a one-bit-per-cycle restoring division, stalls the pipeline while busy, and returns the remainder to HI and the quotient to LO.
- Honours pipeline flushes from exceptions and branches.

---
 rtl/div_seq_if.sv | 26 ++
 rtl/div_seq.sv | 132 +++++++++++++
 tb/tb_div_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Operand/result bundle between the execute-stage control and the divide sequencer.
// The master modport is the pipeline side and the slave modport is the divider side.
interface div_seq_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              signed_div;
    logic              flush;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              stall_req;
    logic              done;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;
    logic              div_by_zero;

    modport master (
        output start, signed_div, flush, a, b,
        input  stall_req, done, hi_out, lo_out, div_by_zero
    );

    modport slave (
        input  start, signed_div, flush, a, b,
        output stall_req, done, hi_out, lo_out, div_by_zero
    );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider for MIPS DIV/DIVU; HI gets the remainder, LO the quotient.
// Latency: done DATA_W+1 cycles after start (1 for b==0, or |a|<|b| when DIV_EARLY_OUT_EN).
// Backpressure: stall_req holds the pipeline while busy; flush aborts with no done pulse.
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);
    localparam int            CW   = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q;
    logic              sign_q, sign_r, bz_q;
    logic [DATA_W-1:0] a_q, dvs_q, rem_q, quo_q;
    logic [DATA_W-1:0] hi_q, lo_q;
    logic              dz_q;

    logic [DATA_W-1:0] abs_a, abs_b;
    logic              b_zero, early, accept;
    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] diff;
    logic              borrow;
    logic [DATA_W-1:0] lo_res, hi_res;

    assign abs_a  = (bus.signed_div && bus.a[DATA_W-1]) ? -bus.a : bus.a;
    assign abs_b  = (bus.signed_div && bus.b[DATA_W-1]) ? -bus.b : bus.b;
    assign b_zero = (bus.b == '0);
    assign accept = bus.start && !bus.flush;

`ifdef DIV_EARLY_OUT_EN
    assign early = !b_zero && (abs_a < abs_b);
`else
    assign early = 1'b0;
`endif

    // Upper half shifted left with the next dividend bit; the MSB of diff is the borrow.
    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dvs_q};
    assign borrow  = diff[DATA_W+1];

    assign lo_res = bz_q ? '1  : (sign_q ? -quo_q : quo_q);
    assign hi_res = bz_q ? a_q : (sign_r ? -rem_q : rem_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (b_zero || early) ? DONE : CALC;
            CALC: begin
                if (bus.flush)             state_d = IDLE;
                else if (count_q == LAST)  state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            bz_q    <= 1'b0;
            a_q     <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    sign_q  <= bus.signed_div & (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
                    sign_r  <= bus.signed_div & bus.a[DATA_W-1];
                    a_q     <= bus.a;
                    dvs_q   <= abs_b;
                    bz_q    <= b_zero;
                    count_q <= '0;
                    if (early) begin
                        rem_q <= abs_a;
                        quo_q <= '0;
                    end else begin
                        rem_q <= '0;
                        quo_q <= abs_a;
                    end
                end
                CALC: if (!bus.flush) begin
                    rem_q   <= borrow ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
                    quo_q   <= {quo_q[DATA_W-2:0], ~borrow};
                    count_q <= count_q + 1'b1;
                end
                DONE: if (!bus.flush) begin
                    hi_q <= hi_res;
                    lo_q <= lo_res;
                    dz_q <= bz_q;
                end
                default: ;
            endcase
        end
    end

    // Results are shown combinationally in DONE so the stalled instruction can write HI/LO
    // in the same cycle it is released.
    always_comb begin
        bus.stall_req   = 1'b0;
        bus.done        = 1'b0;
        bus.hi_out      = hi_q;
        bus.lo_out      = lo_q;
        bus.div_by_zero = dz_q;
        case (state_q)
            IDLE: bus.stall_req = accept;
            CALC: bus.stall_req = 1'b1;
            DONE: if (!bus.flush) begin
                bus.done        = 1'b1;
                bus.hi_out      = hi_res;
                bus.lo_out      = lo_res;
                bus.div_by_zero = bz_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: expected results are queued at issue time and a
// negedge monitor compares each done pulse (cycle, LO, HI, div_by_zero) against the queue.
module tb_div_seq;
    localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_SMALL = 1;
`else
    localparam int LAT_SMALL = 33;
`endif

    typedef struct {
        int unsigned cyc;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    exp_t q[$];

    div_seq_if #(.DATA_W(W)) bus ();

    div_seq #(.DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_done: done high at cycle %0d with nothing outstanding", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("done_cycle", W'(cyc), W'(e.cyc));
                check("lo_out", bus.lo_out, e.lo);
                check("hi_out", bus.hi_out, e.hi);
                check("div_by_zero", W'(bus.div_by_zero), W'(e.dz));
            end
        end
    end

    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lat, input logic [W-1:0] lo, input logic [W-1:0] hi,
                         input logic dz, output int unsigned t);
        exp_t e;
        @(posedge clk);
        #1;
        bus.start = 1'b1; bus.signed_div = sgn; bus.a = a; bus.b = b;
        t = cyc;
        e.cyc = t + lat; e.lo = lo; e.hi = hi; e.dz = dz;
        q.push_back(e);
        @(negedge clk);
        check("stall_at_start", W'(bus.stall_req), 1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d results outstanding after %0d cycles", q.size(), budget);
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned t;
        int highs;
        bus.start = 1'b0; bus.signed_div = 1'b0; bus.flush = 1'b0; bus.a = '0; bus.b = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", W'(bus.done), 0);
        check("rst_hi", bus.hi_out, 0);
        check("rst_lo", bus.lo_out, 0);
        check("rst_dz", W'(bus.div_by_zero), 0);
        check("rst_stall", W'(bus.stall_req), 0);
        #1 rst = 1'b0;

        // DIVU 100/7 with stall window check T..T+32
        issue(1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, t);
        highs = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus.stall_req === 1'b1) highs++;
        end
        check("stall_cycles_calc", W'(highs), 32);
        @(negedge clk);
        check("stall_low_in_done", W'(bus.stall_req), 0);
        drain(40);

        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, t);
        drain(40);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0, 1'b0, t);
        drain(40);

        issue(1'b0, 32'h1234, 32'h0, 1, 32'hFFFF_FFFF, 32'h1234, 1'b1, t);
        drain(5);
        issue(1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0, t);
        drain(40);

        // Flush mid-calculation, then restart two cycles later
        issue(1'b0, 32'd100, 32'd7, 0, 32'd0, 32'd0, 1'b0, t);
        void'(q.pop_back());
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("stall_after_flush", W'(bus.stall_req), 0);
        check("lo_hold_flush", bus.lo_out, 32'd3);
        check("hi_hold_flush", bus.hi_out, 32'd0);
        issue(1'b0, 32'd9, 32'd4, 33, 32'd2, 32'd1, 1'b0, t);
        drain(40);

        // flush and start together in IDLE: nothing starts
        @(posedge clk);
        #1 bus.start = 1'b1; bus.flush = 1'b1; bus.a = 32'd5; bus.b = 32'd1;
        @(negedge clk);
        check("stall_flush_start", W'(bus.stall_req), 0);
        @(posedge clk);
        #1 bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        check("idle_after_flush_start", W'(bus.stall_req), 0);
        repeat (40) @(posedge clk);

        // start held high: back-to-back divides at T+33 and T+67
        @(posedge clk);
        #1 bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd20; bus.b = 32'd6;
        t = cyc;
        q.push_back('{cyc: t + 33, lo: 32'd3, hi: 32'd2, dz: 1'b0});
        q.push_back('{cyc: t + 67, lo: 32'd3, hi: 32'd2, dz: 1'b0});
        repeat (68) @(posedge clk);
        #1 bus.start = 1'b0;
        drain(10);
        repeat (40) @(posedge clk);

        issue(1'b0, 32'd3, 32'd10, LAT_SMALL, 32'd0, 32'd3, 1'b0, t);
        drain(40);
        repeat (40) @(posedge clk);

        check("queue_empty", W'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
